// File: rtl/io_ring_pkg.sv
// Shared types for the IO ring power sequencer: FSM state encoding and sizing helpers.
package io_ring_pkg;

  localparam int unsigned IO_SEQ_STATE_W = 3;

  typedef enum logic [IO_SEQ_STATE_W-1:0] {
    ST_OFF    = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_IE_ON  = 3'd3,
    ST_GRP    = 3'd4,
    ST_READY  = 3'd5,
    ST_DOWN   = 3'd6
  } io_seq_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/io_sync_bit.sv
// Multi-flop single-bit synchroniser, synchronous active-high reset to 0.
module io_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/io_ring_pwr_seq.sv
// GF22 1.8V IO ring power sequencer: retention hold, staggered group enables, safe revert on loss.
// ready_o rises SETTLE_CYC+2+N_GROUPS*GAP_CYC cycles after ok_s rises. Optional: IO_SEQ_LOSS_CNT_EN.
module io_ring_pwr_seq
  import io_ring_pkg::*;
#(
  parameter int unsigned N_GROUPS    = 4,
  parameter int unsigned SETTLE_CYC  = 256,
  parameter int unsigned GAP_CYC     = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vddio_ok_i,
  input  logic                      seq_en_i,
  output logic                      pad_ret_o,
  output logic                      pad_ie_o,
  output logic [N_GROUPS-1:0]       grp_oe_o,
  output logic                      ready_o,
  output logic                      fault_o,
  output logic [IO_SEQ_STATE_W-1:0] state_o
`ifdef IO_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0]                loss_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(max_u(SETTLE_CYC, GAP_CYC) + 1);
  localparam int unsigned IDX_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_GROUPS - 1);

  io_seq_state_e     state;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              ok_s;
  logic              powered;

  io_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (vddio_ok_i),
    .q   (ok_s)
  );

  // States in which the pads may be driven, so losing VDDIO is a fault.
  assign powered = (state == ST_IE_ON) || (state == ST_GRP) ||
                   (state == ST_READY) || (state == ST_DOWN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      cnt       <= '0;
      idx       <= '0;
      pad_ret_o <= 1'b1;
      pad_ie_o  <= 1'b0;
      grp_oe_o  <= '0;
      ready_o   <= 1'b0;
      fault_o   <= 1'b0;
    end else begin
      fault_o <= 1'b0;
      if (!ok_s && powered) begin
        // Loss overrides everything: drop all drivers at once, no staggering.
        state     <= seq_en_i ? ST_WAIT : ST_OFF;
        cnt       <= '0;
        idx       <= '0;
        pad_ret_o <= 1'b1;
        pad_ie_o  <= 1'b0;
        grp_oe_o  <= '0;
        ready_o   <= 1'b0;
        fault_o   <= 1'b1;
      end else begin
        case (state)
          ST_OFF: begin
            if (seq_en_i) state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (!seq_en_i) begin
              state <= ST_OFF;
            end else if (ok_s) begin
              state <= ST_SETTLE;
              cnt   <= SETTLE_LD;
            end
          end
          ST_SETTLE: begin
            if (!ok_s) begin
              state <= ST_WAIT;
            end else if (!seq_en_i) begin
              state <= ST_DOWN;
              cnt   <= GAP_LD;
            end else if (cnt == '0) begin
              state     <= ST_IE_ON;
              pad_ret_o <= 1'b0;
              pad_ie_o  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          ST_IE_ON: begin
            if (!seq_en_i) begin
              state <= ST_DOWN;
              cnt   <= GAP_LD;
            end else begin
              state    <= ST_GRP;
              idx      <= '0;
              grp_oe_o <= N_GROUPS'(1);
              cnt      <= GAP_LD;
            end
          end
          ST_GRP: begin
            if (!seq_en_i) begin
              state <= ST_DOWN;
              cnt   <= GAP_LD;
            end else if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (idx == LAST_IDX) begin
              state   <= ST_READY;
              ready_o <= 1'b1;
            end else begin
              idx      <= idx + 1'b1;
              grp_oe_o <= grp_oe_o | (N_GROUPS'(1) << (idx + IDX_W'(1)));
              cnt      <= GAP_LD;
            end
          end
          ST_READY: begin
            if (!seq_en_i) begin
              state   <= ST_DOWN;
              ready_o <= 1'b0;
              cnt     <= GAP_LD;
            end
          end
          ST_DOWN: begin
            // Enables form a contiguous low run, so shifting right drops the highest group.
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else if (grp_oe_o != '0) begin
              grp_oe_o <= grp_oe_o >> 1;
              cnt      <= GAP_LD;
            end else begin
              state     <= ST_OFF;
              pad_ie_o  <= 1'b0;
              pad_ret_o <= 1'b1;
            end
          end
          default: state <= ST_OFF;
        endcase
      end
    end
  end

  assign state_o = state;

`ifdef IO_SEQ_LOSS_CNT_EN
  // Saturating count of fault pulses, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst)                               loss_cnt_o <= 8'd0;
    else if (fault_o && loss_cnt_o != 8'hFF) loss_cnt_o <= loss_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Self-checking bench for io_ring_pwr_seq; expectations derived from event times by arithmetic.
module tb_io_ring_pwr_seq;

  localparam int N  = 4;
  localparam int S  = 8;
  localparam int G  = 2;
  localparam int SY = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       vddio_ok_i;
  logic       seq_en_i;
  logic       pad_ret_o;
  logic       pad_ie_o;
  logic [3:0] grp_oe_o;
  logic       ready_o;
  logic       fault_o;
  logic [2:0] state_o;
`ifdef IO_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt_o;
`endif

  io_ring_pwr_seq #(
    .N_GROUPS(N), .SETTLE_CYC(S), .GAP_CYC(G), .SYNC_STAGES(SY)
  ) dut (
    .clk(clk), .rst(rst), .vddio_ok_i(vddio_ok_i), .seq_en_i(seq_en_i),
    .pad_ret_o(pad_ret_o), .pad_ie_o(pad_ie_o), .grp_oe_o(grp_oe_o),
    .ready_o(ready_o), .fault_o(fault_o), .state_o(state_o)
`ifdef IO_SEQ_LOSS_CNT_EN
    , .loss_cnt_o(loss_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;
  int n      = 0;
  int ie_t   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n++;
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int mask(input int k);
    return (1 << k) - 1;
  endfunction

  // Groups enabled t cycles after release in an undisturbed power-up.
  function automatic int up_groups(input int t);
    return (t >= ie_t + 1) ? min_i(N, (t - ie_t - 1) / G + 1) : 0;
  endfunction

  task automatic up_chk();
    chk("up_ie",    32'(pad_ie_o),  32'(n >= ie_t));
    chk("up_ret",   32'(pad_ret_o), 32'(n < ie_t));
    chk("up_grp",   32'(grp_oe_o),  32'(mask(up_groups(n))));
    chk("up_ready", 32'(ready_o),   32'(n >= ie_t + 1 + N * G));
    chk("up_fault", 32'(fault_o),   32'(0));
    if (n >= ie_t)
      chk("up_state", 32'(state_o),
          32'((n >= ie_t + 1 + N * G) ? 5 : (n >= ie_t + 1) ? 4 : 3));
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) begin
      tick();
      chk("rst_ret",   32'(pad_ret_o), 32'(1));
      chk("rst_ie",    32'(pad_ie_o),  32'(0));
      chk("rst_grp",   32'(grp_oe_o),  32'(0));
      chk("rst_ready", 32'(ready_o),   32'(0));
      chk("rst_fault", 32'(fault_o),   32'(0));
      chk("rst_state", 32'(state_o),   32'(0));
    end
    rst = 1'b0;
    n   = 0;
  endtask

  int ge, gl, d, c, cl, off_t, rdy, drop_seq, r, w;

  initial begin
    rst        = 1'b1;
    vddio_ok_i = 1'b1;
    seq_en_i   = 1'b1;
    rdy        = SY + S + 1 + 1 + N * G;

    // Reset held with supply and permission present, then clean power-up.
    do_reset(3);
    ie_t = SY + S + 1;
    repeat (ie_t + 1 + N * G + 3) begin
      tick();
      up_chk();
    end

    // Supply glitch during settling restarts the settle count, no fault.
    for (int it = 0; it < 3; it++) begin
      do_reset(1);
      ge   = $urandom_range(2, 8);
      gl   = $urandom_range(2, 4);
      ie_t = ge + gl + SY + S + 1;
      repeat (ie_t + 1 + N * G + 2) begin
        tick();
        if (n == ge)      vddio_ok_i = 1'b0;
        if (n == ge + gl) vddio_ok_i = 1'b1;
        up_chk();
        if (n == ge + SY + 1) chk("glitch_wait", 32'(state_o), 32'(1));
      end
    end

    // Supply loss while driving: immediate safe state, one fault pulse.
    ie_t = SY + S + 1;
    for (int it = 0; it < 4; it++) begin
      do_reset(1);
      d        = $urandom_range(ie_t - 2, rdy + 2);
      drop_seq = $urandom_range(0, 1);
      repeat (d + 2) begin
        tick();
        if (n == d) vddio_ok_i = 1'b0;
        if (n == d + 2 && drop_seq == 1) seq_en_i = 1'b0;
        up_chk();
      end
      tick();
      chk("loss_grp",   32'(grp_oe_o),  32'(0));
      chk("loss_ret",   32'(pad_ret_o), 32'(1));
      chk("loss_ie",    32'(pad_ie_o),  32'(0));
      chk("loss_ready", 32'(ready_o),   32'(0));
      chk("loss_fault", 32'(fault_o),   32'(1));
      chk("loss_state", 32'(state_o),   32'(drop_seq == 1 ? 0 : 1));
      tick();
      chk("loss_pulse", 32'(fault_o),   32'(0));
      chk("loss_hold",  32'(grp_oe_o),  32'(0));
      vddio_ok_i = 1'b1;
      seq_en_i   = 1'b1;
    end

    // Orderly power-down: groups released highest first, then retention.
    for (int it = 0; it < 4; it++) begin
      do_reset(1);
      d = (it == 0) ? rdy + 1 : $urandom_range(ie_t, rdy + 4);
      repeat (d) begin
        tick();
        up_chk();
      end
      c        = up_groups(d);
      seq_en_i = 1'b0;
      off_t    = d + 1 + (c + 1) * G;
      repeat (off_t - d + 2) begin
        tick();
        cl = min_i(c, (n - d - 1) / G);
        chk("dn_grp",   32'(grp_oe_o),  32'(mask(c - cl)));
        chk("dn_ie",    32'(pad_ie_o),  32'(n < off_t));
        chk("dn_ret",   32'(pad_ret_o), 32'(n >= off_t));
        chk("dn_ready", 32'(ready_o),   32'(0));
        chk("dn_fault", 32'(fault_o),   32'(0));
        chk("dn_state", 32'(state_o),   32'((n < off_t) ? 6 : 0));
      end
      seq_en_i = 1'b1;
    end

    // Reset asserted mid-sequence takes effect at the same edge.
    do_reset(1);
    r = $urandom_range(ie_t + 1, rdy - 1);
    repeat (r) begin
      tick();
      up_chk();
    end
    do_reset(1);

`ifdef IO_SEQ_LOSS_CNT_EN
    for (int e = 0; e < 300; e++) begin
      w = 0;
      while (!pad_ie_o && w < 64) begin
        tick();
        w++;
      end
      if (w >= 64) begin
        chk("loss_cnt_timeout", 32'(pad_ie_o), 32'(1));
        break;
      end
      vddio_ok_i = 1'b0;
      repeat (4) tick();
      vddio_ok_i = 1'b1;
    end
    repeat (3) tick();
    chk("loss_cnt_sat", 32'(loss_cnt_o), 32'(255));
    do_reset(1);
    chk("loss_cnt_rst", 32'(loss_cnt_o), 32'(0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
